// File: rtl/dig_scan_ctrl.sv
// Multiplexed 7-segment scan controller: time-slices N_DIG hex digits onto one
// segment bus with a per-slot anti-ghost blank window and a frame wrap pulse.
module dig_scan_ctrl #(
    parameter int N_DIG       = 6,
    parameter int DIV         = 50000,
    parameter int GUARD       = 2,
    parameter int SEL_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic [4*N_DIG-1:0]                            digits,
    input  logic [N_DIG-1:0]                              dp_mask,
    input  logic [N_DIG-1:0]                              blank_mask,
    output logic [N_DIG-1:0]                              sel,
    output logic [7:0]                                    seg,
    output logic [((N_DIG > 1) ? $clog2(N_DIG) : 1)-1:0]  scan_idx,
    output logic                                          frame_tick
);

    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    P_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0]    P_GUARD = PW'(GUARD);
    localparam logic [IW-1:0]    I_LAST  = IW'(N_DIG - 1);
    // XOR masks that turn the active-high internal view into pin polarity
    localparam logic [N_DIG-1:0] SEL_INV = {N_DIG{SEL_ACT_LOW != 0}};
    localparam logic [7:0]       SEG_INV = {8{SEG_ACT_LOW != 0}};

    logic [PW-1:0]    r_pcnt;
    logic [IW-1:0]    r_idx;
    logic             r_tick;
    logic [N_DIG-1:0] r_sel;
    logic [7:0]       r_seg;

    logic [3:0]       w_nib;
    logic             w_dp;
    logic             w_blank;
    logic             w_on;
    logic [N_DIG-1:0] w_sel_hi;
    logic [7:0]       w_seg_hi;

    function automatic logic [6:0] f_seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Explicit compare loop keeps the selection in range when N_DIG is not a power of two
    always_comb begin
        w_nib   = '0;
        w_dp    = 1'b0;
        w_blank = 1'b0;
        for (int unsigned k = 0; k < N_DIG; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib   = digits[4*k +: 4];
                w_dp    = dp_mask[k];
                w_blank = blank_mask[k];
            end
        end
        w_on = en && (r_pcnt >= P_GUARD) && !w_blank;
        for (int unsigned k = 0; k < N_DIG; k++) begin
            w_sel_hi[k] = w_on && (r_idx == IW'(k));
        end
        w_seg_hi = w_on ? {w_dp, f_seg7(w_nib)} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
            r_idx  <= '0;
            r_tick <= 1'b0;
            r_sel  <= SEL_INV;
            r_seg  <= SEG_INV;
        end else begin
            r_tick <= 1'b0;
            if (en) begin
                if (r_pcnt == P_LAST) begin
                    r_pcnt <= '0;
                    if (r_idx == I_LAST) begin
                        r_idx  <= '0;
                        r_tick <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end else begin
                    r_pcnt <= r_pcnt + 1'b1;
                end
            end
            r_sel <= w_sel_hi ^ SEL_INV;
            r_seg <= w_seg_hi ^ SEG_INV;
        end
    end

    assign sel        = r_sel;
    assign seg        = r_seg;
    assign scan_idx   = r_idx;
    assign frame_tick = r_tick;

endmodule
